// File: rtl/reg_dump_ctrl.sv
// rtl/reg_dump_ctrl.sv - freezes the pipeline and streams every register LSB-first as bytes
// Optional feature macro: REG_DUMP_HEADER_EN (sends a 0xA5 header byte before the registers)
module reg_dump_ctrl #(
  parameter int INST_SZ   = 32,
  parameter int REG_SZ    = 5,
  parameter int DRAIN_CYC = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_dump_req,
  input  logic [INST_SZ-1:0] i_reg,
  input  logic               i_tx_ready,
  output logic [REG_SZ-1:0]  o_debug_addr,
  output logic               o_enable,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  output logic               o_busy,
  output logic               o_done
);

  localparam int NB = INST_SZ / 8;
  localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NB - 1);
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYC - 1);

  typedef enum logic [2:0] {IDLE, DRAIN, HEADER, LOAD, SEND, DONE} state_t;

  state_t             state;
  logic [3:0]         drain_cnt;
  logic [BCW-1:0]     byte_cnt;
  logic [INST_SZ-1:0] shreg;

  // Single FSM: all outputs are registered and change on the same edge as the state.
  // In HEADER and SEND o_tx_valid is always 1, so i_tx_ready alone marks the handshake.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state        <= IDLE;
      drain_cnt    <= '0;
      byte_cnt     <= '0;
      shreg        <= '0;
      o_debug_addr <= '0;
      o_enable     <= 1'b1;
      o_tx_data    <= '0;
      o_tx_valid   <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_dump_req) begin
            state     <= DRAIN;
            o_enable  <= 1'b0;
            o_busy    <= 1'b1;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            drain_cnt <= '0;
`ifdef REG_DUMP_HEADER_EN
            state      <= HEADER;
            o_tx_valid <= 1'b1;
            o_tx_data  <= 8'hA5;
`else
            state      <= LOAD;
`endif
          end else begin
            drain_cnt <= drain_cnt + 4'd1;
          end
        end
`ifdef REG_DUMP_HEADER_EN
        HEADER: begin
          if (i_tx_ready) begin
            state      <= LOAD;
            o_tx_valid <= 1'b0;
          end
        end
`endif
        LOAD: begin
          state      <= SEND;
          o_tx_valid <= 1'b1;
          o_tx_data  <= i_reg[7:0];
          shreg      <= i_reg >> 8;
          byte_cnt   <= '0;
        end
        SEND: begin
          if (i_tx_ready) begin
            if (byte_cnt == LAST_BYTE) begin
              o_tx_valid <= 1'b0;
              if (&o_debug_addr) begin
                state        <= DONE;
                o_done       <= 1'b1;
                o_debug_addr <= '0;
              end else begin
                state        <= LOAD;
                o_debug_addr <= o_debug_addr + REG_SZ'(1);
              end
            end else begin
              o_tx_data <= shreg[7:0];
              shreg     <= shreg >> 8;
              byte_cnt  <= byte_cnt + BCW'(1);
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          o_done   <= 1'b0;
          o_enable <= 1'b1;
          o_busy   <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          o_enable   <= 1'b1;
          o_tx_valid <= 1'b0;
          o_busy     <= 1'b0;
          o_done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/reg_dump_ctrl.md
REG_DUMP_CTRL -- requirements
Module: reg_dump_ctrl

Interface
REQ-001 Parameter INST_SZ, default 32, register width in bits; SHALL be a multiple of 8.
REQ-002 Parameter REG_SZ, default 5, register-file address width; the register count is 2^REG_SZ.
REQ-003 Parameter DRAIN_CYC, default 2, number of freeze cycles before the first read; legal range is 1..15.
REQ-004 Port i_clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-005 Port i_reset, input, 1 bit, asynchronous active-low reset.
REQ-006 Port i_dump_req, input, 1 bit, level request to start a register dump.
REQ-007 Port i_reg, input, INST_SZ bits, register-file debug read data for o_debug_addr; this path is combinational.
REQ-008 Port i_tx_ready, input, 1 bit, byte sink ready.
REQ-009 Port o_debug_addr, output, REG_SZ bits, register-file debug read address.
REQ-010 Port o_enable, output, 1 bit, pipeline enable; low freezes the pipeline.
REQ-011 Port o_tx_data, output, 8 bits, byte to the sink.
REQ-012 Port o_tx_valid, output, 1 bit, o_tx_data is valid.
REQ-013 Port o_busy, output, 1 bit, high whenever the state is not IDLE.
REQ-014 Port o_done, output, 1 bit, one-cycle pulse marking dump completion.

Function
REQ-015 The block SHALL be a registered FSM with states IDLE, DRAIN, HEADER, LOAD, SEND, DONE; all outputs SHALL be registered or decoded from state only.
REQ-016 In IDLE with i_dump_req=1 at an edge, the FSM SHALL go to DRAIN and o_enable SHALL be 0 from that edge until DONE exits.
REQ-017 DRAIN SHALL last exactly DRAIN_CYC cycles, then go to HEADER (macro defined) or LOAD.
REQ-018 LOAD SHALL last 1 cycle, drive o_debug_addr, and capture i_reg into a shift register at the exit edge, then go to SEND.
REQ-019 SEND SHALL present the shift register bytes LSB-first, INST_SZ/8 bytes per register.
REQ-020 On any handshake, the byte is consumed when o_tx_valid=1 and i_tx_ready=1 at the same edge.
REQ-021 While o_tx_valid=1 and i_tx_ready=0, o_tx_data SHALL hold stable and o_tx_valid SHALL stay 1.
REQ-022 With i_tx_ready held at 1, one byte SHALL transfer per cycle with no bubble inside a register.
REQ-023 After the last byte of a register: if o_debug_addr=2^REG_SZ-1, go to DONE; otherwise increment o_debug_addr and go to LOAD.
REQ-024 o_debug_addr SHALL NOT wrap within a dump; it SHALL return to 0 in DONE.
REQ-025 DONE SHALL last 1 cycle with o_done=1, then go to IDLE; o_enable SHALL be 1 from the DONE exit edge.
REQ-026 i_dump_req SHALL be ignored outside IDLE.
REQ-027 A request still high on return to IDLE SHALL start a new dump at the next edge.
REQ-028 o_tx_valid SHALL be 0 in IDLE, DRAIN, LOAD and DONE.
REQ-029 o_busy SHALL be 1 in every state except IDLE.

Reset
REQ-030 When i_reset=0, the block SHALL asynchronously force state=IDLE, o_enable=1, o_tx_valid=0, o_tx_data=0, o_debug_addr=0, o_busy=0, o_done=0, and clear all counters.
REQ-031 Reset asserted mid-dump SHALL abort the dump immediately; no partial byte and no o_done pulse SHALL be emitted.
REQ-032 After reset release, the first edge SHALL be evaluated from IDLE.

Configuration
REQ-033 With macro REG_DUMP_HEADER_EN defined, HEADER SHALL send one byte 0xA5 (same handshake rules) between DRAIN and LOAD; total bytes = 1 + 2^REG_SZ*INST_SZ/8.
REQ-034 With REG_DUMP_HEADER_EN undefined, HEADER SHALL be absent, DRAIN SHALL go directly to LOAD, and total bytes = 2^REG_SZ*INST_SZ/8.

Verification
REQ-035 Scenario, defaults, macro undefined, i_reg = 0x1000_0000 + addr, ready always 1, 1-cycle req -> 128 bytes; the first four are 00,00,00,10; o_done pulses exactly once; o_enable is low for exactly 2+32*(1+4)+1 = 163 cycles.
REQ-036 Scenario, macro defined, same stimulus -> first byte 0xA5, then 128 register bytes; 164 bytes... correction: 129 bytes total, with o_enable low for 164 cycles.
REQ-037 Scenario, i_tx_ready toggled 1,0,0,1 repeatedly -> o_tx_data is stable while stalled, no byte is lost or duplicated, and the byte stream matches REQ-035.
REQ-038 Scenario, i_reset=0 pulsed while o_debug_addr=7 mid-SEND -> all outputs take reset values in the same cycle and o_enable=1; a subsequent req produces a full dump from address 0.
REQ-039 Scenario, i_dump_req held high continuously -> back-to-back dumps with exactly 1 IDLE cycle between them; pulses of req during SEND are ignored.
